// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS32 pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned TAM_REG = 5;
    localparam logic [TAM_REG-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        EST_NORMAL     = 1'b0,
        EST_ESPERA_MEM = 1'b1
    } estado_t;

endpackage

// File: rtl/unidade_hazard_if.sv
// Pipeline-side signal bundle of the hazard unit: hazard sources in, stall/flush controls out.
interface unidade_hazard_if
    import hazard_pkg::*;
#(
    parameter int unsigned CONT_TAM = 32
);
    logic [TAM_REG-1:0]  id_rs;
    logic [TAM_REG-1:0]  id_rt;
    logic                id_usa_rs;
    logic                id_usa_rt;
    logic                ex_mem_read;
    logic [TAM_REG-1:0]  ex_rt;
    logic                desvio_tomado;
    logic                mem_req;
    logic                mem_pronto;
    logic                limpar_contadores;

    logic                pc_parada;
    logic                parada_ifid;
    logic                limpar_ifid;
    logic                parada_idex;
    logic                limpar_idex;
    logic                parada_exmem;
    logic                limpar_exmem;
    logic                parada_memwb;
    logic                limpar_memwb;
    logic                erro_timeout;
    logic [CONT_TAM-1:0] contador_paradas;
    logic [CONT_TAM-1:0] contador_descartes;

    // Pipeline side: drives hazard sources, consumes controls.
    modport master (
        output id_rs, id_rt, id_usa_rs, id_usa_rt, ex_mem_read, ex_rt,
               desvio_tomado, mem_req, mem_pronto, limpar_contadores,
        input  pc_parada, parada_ifid, limpar_ifid, parada_idex, limpar_idex,
               parada_exmem, limpar_exmem, parada_memwb, limpar_memwb,
               erro_timeout, contador_paradas, contador_descartes
    );

    // Hazard unit side.
    modport slave (
        input  id_rs, id_rt, id_usa_rs, id_usa_rt, ex_mem_read, ex_rt,
               desvio_tomado, mem_req, mem_pronto, limpar_contadores,
        output pc_parada, parada_ifid, limpar_ifid, parada_idex, limpar_idex,
               parada_exmem, limpar_exmem, parada_memwb, limpar_memwb,
               erro_timeout, contador_paradas, contador_descartes
    );

endinterface

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module contador_saturado #(
    parameter int unsigned TAM = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           limpar,
    input  logic           inc,
    output logic [TAM-1:0] valor
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor <= '0;
        end else if (limpar) begin
            valor <= '0;
        end else if (inc && (valor != '1)) begin
            valor <= valor + 1'b1;
        end
    end

endmodule

// File: rtl/unidade_hazard.sv
// Hazard controller: load-use stalls, taken-branch flushes and memory waits with timeout,
// plus saturating stall/flush statistics.
module unidade_hazard
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CONT_TAM = 32
) (
    input logic             clock,
    input logic             reset,
    unidade_hazard_if.slave hz
);

    localparam int unsigned CNT_TAM = $clog2(TIMEOUT + 1);
    localparam logic [CNT_TAM-1:0] CNT_MAX = CNT_TAM'(TIMEOUT);

    estado_t              estado;
    logic [CNT_TAM-1:0]   cnt;

    logic espera;
    logic stall_mem;
    logic load_use;
    logic descarte;

    logic pc_parada;
    logic parada_ifid;
    logic limpar_ifid;
    logic parada_idex;
    logic limpar_idex;
    logic parada_exmem;
    logic limpar_exmem;
    logic parada_memwb;
    logic limpar_memwb;

    assign espera = (estado == EST_ESPERA_MEM);

    assign stall_mem = (!espera && hz.mem_req && !hz.mem_pronto) ||
                       (espera && !hz.mem_pronto && (cnt < CNT_MAX));

    assign load_use = hz.ex_mem_read && (hz.ex_rt != REG_ZERO) &&
                      ((hz.id_usa_rs && (hz.ex_rt == hz.id_rs)) ||
                       (hz.id_usa_rt && (hz.ex_rt == hz.id_rt)));

    // Wait abandoned: the release cycle carries no stall, only the error pulse.
    assign hz.erro_timeout = !reset && espera && !hz.mem_pronto && (cnt == CNT_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= EST_NORMAL;
            cnt    <= '0;
        end else begin
            unique case (estado)
                EST_NORMAL: begin
                    if (stall_mem) begin
                        estado <= EST_ESPERA_MEM;
                        cnt    <= CNT_TAM'(1);
                    end
                end
                EST_ESPERA_MEM: begin
                    if (stall_mem) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        estado <= EST_NORMAL;
                        cnt    <= '0;
                    end
                end
            endcase
        end
    end

    // Masked branch/load-use is not latched: EX and ID are frozen, so it reappears on release.
    always_comb begin
        pc_parada    = 1'b0;
        parada_ifid  = 1'b0;
        limpar_ifid  = 1'b0;
        parada_idex  = 1'b0;
        limpar_idex  = 1'b0;
        parada_exmem = 1'b0;
        limpar_exmem = 1'b0;
        parada_memwb = 1'b0;
        limpar_memwb = 1'b0;
        descarte     = 1'b0;
        if (reset) begin
            limpar_ifid  = 1'b1;
            limpar_idex  = 1'b1;
            limpar_exmem = 1'b1;
            limpar_memwb = 1'b1;
        end else if (stall_mem) begin
            pc_parada    = 1'b1;
            parada_ifid  = 1'b1;
            parada_idex  = 1'b1;
            parada_exmem = 1'b1;
            limpar_memwb = 1'b1;
        end else if (hz.desvio_tomado) begin
            limpar_ifid = 1'b1;
            limpar_idex = 1'b1;
            descarte    = 1'b1;
        end else if (load_use) begin
            pc_parada   = 1'b1;
            parada_ifid = 1'b1;
            limpar_idex = 1'b1;
        end
    end

    assign hz.pc_parada    = pc_parada;
    assign hz.parada_ifid  = parada_ifid;
    assign hz.limpar_ifid  = limpar_ifid;
    assign hz.parada_idex  = parada_idex;
    assign hz.limpar_idex  = limpar_idex;
    assign hz.parada_exmem = parada_exmem;
    assign hz.limpar_exmem = limpar_exmem;
    assign hz.parada_memwb = parada_memwb;
    assign hz.limpar_memwb = limpar_memwb;

    contador_saturado #(
        .TAM (CONT_TAM)
    ) u_cont_paradas (
        .clock  (clock),
        .reset  (reset),
        .limpar (hz.limpar_contadores),
        .inc    (pc_parada),
        .valor  (hz.contador_paradas)
    );

    contador_saturado #(
        .TAM (CONT_TAM)
    ) u_cont_descartes (
        .clock  (clock),
        .reset  (reset),
        .limpar (hz.limpar_contadores),
        .inc    (descarte),
        .valor  (hz.contador_descartes)
    );

endmodule

// File: doc/unidade_hazard.md
# unidade_hazard

Pipeline hazard controller for the 5-stage MIPS32 core. It generates the per-register stall (`parada`) and flush (`limpar`) controls consumed by the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC stall. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory/UART waits with a timeout. It keeps saturating stall/flush statistics counters for debug readout over UART.

## Interface
- `TIMEOUT`, 16: maximum stalled cycles per memory access before forced release (≥1).
- `CONT_TAM`, 32: width of statistics counters.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_usa_rs`, `id_usa_rt` in 1: ID instruction actually reads rs / rt.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_rt` in 5: destination of the load in EX.
- `desvio_tomado` in 1: branch/jump resolved taken in EX.
- `mem_req` in 1: instruction in MEM accesses data memory/UART (level, held while in MEM).
- `mem_pronto` in 1: memory access completes this cycle.
- `limpar_contadores` in 1: synchronous clear of both counters.
- `pc_parada` out 1: hold PC.
- `parada_ifid`, `limpar_ifid`, `parada_idex`, `limpar_idex`, `parada_exmem`, `limpar_exmem`, `parada_memwb`, `limpar_memwb` out 1 each: controls for each pipeline register.
- `erro_timeout` out 1: one-cycle pulse, memory access abandoned.
- `contador_paradas` out CONT_TAM: cycles with `pc_parada`=1.
- `contador_descartes` out CONT_TAM: cycles with the branch flush applied.

## Operation
- FSM states: NORMAL, ESPERA_MEM. Wait counter `cnt` is `$clog2(TIMEOUT+1)` bits.
- `stall_mem` is asserted in two cases:
  - NORMAL with `mem_req`=1 and `mem_pronto`=0.
  - ESPERA_MEM with `mem_pronto`=0 and `cnt`<TIMEOUT.
- State transitions:
  - NORMAL → ESPERA_MEM when `stall_mem`; `cnt`←1.
  - ESPERA_MEM with `stall_mem`: `cnt`←`cnt`+1.
  - ESPERA_MEM with `mem_pronto`=1: release, next state NORMAL.
  - ESPERA_MEM with `mem_pronto`=0 and `cnt`==TIMEOUT: release, `erro_timeout`=1 this cycle, next state NORMAL.
- Zero-wait access (`mem_req`=`mem_pronto`=1 in NORMAL): no stall, state unchanged.
- `load_use` = `ex_mem_read` & (`ex_rt`≠0) & ((`id_usa_rs` & `ex_rt`==`id_rs`) | (`id_usa_rt` & `ex_rt`==`id_rt`)).
- Output priority, first match wins; unlisted outputs are 0:
  1. `reset`=1: all four `limpar_*`=1.
  2. `stall_mem`: `pc_parada`, `parada_ifid`, `parada_idex`, `parada_exmem`=1; `limpar_memwb`=1 (bubble into WB).
  3. `desvio_tomado`: `limpar_ifid`=1, `limpar_idex`=1. PC not held, so it loads the target.
  4. `load_use`: `pc_parada`=1, `parada_ifid`=1, `limpar_idex`=1 (one bubble).
- A branch or load-use masked by `stall_mem` is not lost. The EX and ID contents are frozen, so the condition is re-evaluated on the cycle the stall releases.
- Branch has priority over load-use: the stalled ID instruction is wrong-path and is flushed.
- `parada_memwb` and `limpar_exmem` are always 0 outside reset. They are kept for uniformity.
- Counters:
  - `contador_paradas` +1 each cycle `pc_parada`=1.
  - `contador_descartes` +1 each cycle priority 3 is applied.
  - Both saturate at all-ones.
  - `limpar_contadores` overrides increment (value 0 next cycle).

## Timing
- All stall/flush outputs and `erro_timeout` are combinational from current state and inputs. They act on the same rising edge.
- FSM, `cnt` and counters update on the rising edge.
- Reset values: state NORMAL, `cnt`=0, both counters 0, `erro_timeout`=0. Stall/flush outputs follow priority 1.
- Reset mid-wait aborts the access immediately. No `erro_timeout` is raised.
- Maximum stall per access: TIMEOUT cycles. The release cycle follows, with or without `mem_pronto`.
- Back-to-back accesses: the next MEM instruction is evaluated in NORMAL the cycle after release. It can stall again with no gap cycle.
- `mem_pronto` while `mem_req`=0 in NORMAL is ignored.

## Structure
- Shared package `hazard_pkg`:
  - State encoding constants `EST_NORMAL`, `EST_ESPERA_MEM`.
  - `REG_ZERO` = 5'd0.
  - `TAM_REG` = 5.
- One sub-module: `contador_saturado` (parameter `TAM`; ports `clock`, `reset`, `limpar`, `inc`, `valor`). Instantiated twice.
- Combinational priority logic and FSM live in `unidade_hazard`.

## Test plan
- **Load-use.** `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8, `id_usa_rs`=1 → `pc_parada`=`parada_ifid`=`limpar_idex`=1 for exactly one cycle. `contador_paradas`=1. With `ex_rt`=0 → no stall.
- **Branch flush.** `desvio_tomado`=1 with a simultaneous load-use → `limpar_ifid`=`limpar_idex`=1, `pc_parada`=0. `contador_descartes` increments by 1.
- **Memory wait.** `mem_req`=1, `mem_pronto` rises 3 cycles later → 3 cycles of freeze with `limpar_memwb`=1. Released on the 4th cycle. `contador_paradas`=3.
- **Timeout.** TIMEOUT=4, `mem_req`=1, `mem_pronto` never rises → 4 stalled cycles, then a one-cycle `erro_timeout`=1 with no stall. State returns to NORMAL.
- **Masked branch.** `desvio_tomado`=1 during `stall_mem` → no flush until the release cycle, then flush. Zero-wait access (`mem_req`=`mem_pronto`=1) → no stall.
- **Reset and counters.** Assert `reset` in cycle 2 of a wait → all `limpar_*`=1, state NORMAL, counters 0. Force a counter to all-ones with `CONT_TAM`=4 → it holds 15. `limpar_contadores` → 0.
